pixel_clip_fifo: RTL and testbench

//  Sits between the Reuleaux-triangle drawer's pixel outputs and the VGA adapter write port.

---
 rtl/pixel_clip_fifo_if.sv | 25 ++
 rtl/pixel_clip_fifo.sv | 107 ++++++++++
 tb/tb_pixel_clip_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_clip_fifo_if.sv
// rtl/pixel_clip_fifo_if.sv - drawer-side and adapter-side pixel handshake bundle
interface pixel_clip_fifo_if;
  logic [8:0] in_x;
  logic [7:0] in_y;
  logic [2:0] in_colour;
  logic       in_plot;
  logic       in_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       vga_ready;

  // The clip FIFO itself: consumes drawer pixels, produces adapter writes
  modport slave (
    input  in_x, in_y, in_colour, in_plot, vga_ready,
    output in_ready, vga_x, vga_y, vga_colour, vga_plot
  );

  // Drawer plus adapter seen as one peer
  modport master (
    output in_x, in_y, in_colour, in_plot, vga_ready,
    input  in_ready, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/pixel_clip_fifo.sv
// rtl/pixel_clip_fifo.sv - off-screen pixel clipper feeding a FWFT FIFO to the VGA adapter
module pixel_clip_fifo #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DEPTH    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  pixel_clip_fifo_if.slave   pix,
  output logic               idle,
  output logic [15:0]        plot_count,
  output logic [15:0]        clip_count
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   LP_FULL = (AW+1)'(DEPTH);
  localparam logic [8:0]    LP_W    = 9'(SCREEN_W);
  localparam logic [7:0]    LP_H    = 8'(SCREEN_H);

  // Entry layout: {x[7:0], y[6:0], colour[2:0]}
  logic [17:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_plot_cnt;
  logic [15:0]   r_clip_cnt;

  logic          w_off;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [17:0]   w_head;

  // A negative coordinate shows up as its sign bit; otherwise the low bits are the magnitude
  assign w_off = pix.in_x[8] | pix.in_y[7]
               | ({1'b0, pix.in_x[7:0]} >= LP_W)
               | ({1'b0, pix.in_y[6:0]} >= LP_H);

  assign pix.in_ready = (r_count != LP_FULL) && !clr;
  assign w_accept     = pix.in_plot && pix.in_ready;
  assign w_push       = w_accept && !w_off;
  assign w_empty      = (r_count == '0);
  // clr wins over a pop in the same cycle
  assign w_pop        = !w_empty && pix.vga_ready && !clr;

  // Head fields are forced to zero while empty so nothing stale is shown after reset
  assign w_head         = r_mem[r_rd_ptr];
  assign pix.vga_plot   = !w_empty;
  assign pix.vga_x      = w_empty ? '0 : w_head[17:10];
  assign pix.vga_y      = w_empty ? '0 : w_head[9:3];
  assign pix.vga_colour = w_empty ? '0 : w_head[2:0];

  assign idle       = w_empty && !w_push;
  assign plot_count = r_plot_cnt;
  assign clip_count = r_clip_cnt;

  // Storage array: written only on an on-screen accept, never reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {pix.in_x[7:0], pix.in_y[6:0], pix.in_colour};
    end
  end

  // Pointer and occupancy tracking; push and pop together leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  // Saturating plotted/clipped pixel statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plot_cnt <= '0;
      r_clip_cnt <= '0;
    end else if (clr) begin
      r_plot_cnt <= '0;
      r_clip_cnt <= '0;
    end else if (w_accept) begin
      if (!w_off && (r_plot_cnt != 16'hFFFF)) begin
        r_plot_cnt <= r_plot_cnt + 16'd1;
      end
      if (w_off && (r_clip_cnt != 16'hFFFF)) begin
        r_clip_cnt <= r_clip_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_pixel_clip_fifo.sv
// tb/tb_pixel_clip_fifo.sv - scoreboard bench for the pixel clip FIFO
module tb_pixel_clip_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        idle;
  logic [15:0] plot_count;
  logic [15:0] clip_count;

  pixel_clip_fifo_if pif ();

  pixel_clip_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .pix        (pif),
    .idle       (idle),
    .plot_count (plot_count),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          n_pop = 0;
  int          exp_plot = 0;
  int          exp_clip = 0;
  bit          rand_ready = 0;
  logic [17:0] q[$];

  // Model: evaluated at negedge, predicts what the next posedge will do
  initial begin
    int   xs;
    int   ys;
    bit   off;
    bit   exp_rdy;
    bit   exp_idle;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_plot = 0;
        exp_clip = 0;
      end else begin
        xs = $signed(pif.in_x);
        ys = $signed(pif.in_y);
        off = (xs < 0) || (xs >= 160) || (ys < 0) || (ys >= 120);
        exp_rdy  = (q.size() != 16) && !clr;
        exp_idle = (q.size() == 0) && !(pif.in_plot && exp_rdy && !off);
        total++;
        if (pif.in_ready !== exp_rdy) begin
          bad++; $display("FAIL in_ready got=%b want=%b t=%0t", pif.in_ready, exp_rdy, $time);
        end
        total++;
        if (pif.vga_plot !== (q.size() != 0)) begin
          bad++; $display("FAIL vga_plot got=%b want=%b t=%0t", pif.vga_plot, q.size() != 0, $time);
        end
        total++;
        if (idle !== exp_idle) begin
          bad++; $display("FAIL idle got=%b want=%b t=%0t", idle, exp_idle, $time);
        end
        total++;
        if (plot_count !== 16'(exp_plot) || clip_count !== 16'(exp_clip)) begin
          bad++; $display("FAIL counters got=%0d/%0d want=%0d/%0d t=%0t", plot_count, clip_count, exp_plot, exp_clip, $time);
        end
        if (q.size() != 0) begin
          total++;
          if ({pif.vga_x, pif.vga_y, pif.vga_colour} !== q[0]) begin
            bad++; $display("FAIL head got=%h want=%h t=%0t", {pif.vga_x, pif.vga_y, pif.vga_colour}, q[0], $time);
          end
        end
        if (clr) begin
          q.delete();
          exp_plot = 0;
          exp_clip = 0;
        end else begin
          if (q.size() != 0 && pif.vga_ready) begin
            total++;
            if (pif.vga_x >= 8'd160 || pif.vga_y >= 7'd120) begin
              bad++; $display("FAIL onscreen got=(%0d,%0d) want=<(160,120)", pif.vga_x, pif.vga_y);
            end
            void'(q.pop_front());
            n_pop++;
          end
          if (pif.in_plot && exp_rdy) begin
            if (off) begin
              if (exp_clip != 65535) exp_clip++;
            end else begin
              q.push_back({pif.in_x[7:0], pif.in_y[6:0], pif.in_colour});
              if (exp_plot != 65535) exp_plot++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) pif.vga_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_px(input int x, input int y, input logic [2:0] c);
    bit acc;
    pif.in_x = 9'(x);
    pif.in_y = 8'(y);
    pif.in_colour = c;
    pif.in_plot = 1'b1;
    acc = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = (pif.in_ready === 1'b1);
      tick();
    end
    pif.in_plot = 1'b0;
    total++;
    if (!acc) begin
      bad++; $display("FAIL push_timeout got=stalled want=accepted (%0d,%0d)", x, y);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain_timeout got=%0d want=0 entries", q.size());
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    rst_n = 1'b1;
    total++;
    if (pif.vga_plot !== 1'b0 || pif.vga_x !== 8'd0 || pif.vga_y !== 7'd0 || pif.vga_colour !== 3'd0) begin
      bad++; $display("FAIL reset_head got=%b/%h want=0/0", pif.vga_plot, {pif.vga_x, pif.vga_y, pif.vga_colour});
    end
    total++;
    if (pif.in_ready !== 1'b1 || idle !== 1'b1 || plot_count !== 16'd0 || clip_count !== 16'd0) begin
      bad++; $display("FAIL reset_state got=%b%b %0d %0d want=11 0 0", pif.in_ready, idle, plot_count, clip_count);
    end
    pif.vga_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_px(10 + i, 20 + i, 3'(i));
    total++;
    if (pif.vga_plot !== 1'b1) begin
      bad++; $display("FAIL prefill_plot got=%b want=1", pif.vga_plot);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pif.vga_plot !== 1'b0 || pif.in_ready !== 1'b1 || idle !== 1'b1) begin
      bad++; $display("FAIL midreset got=%b%b%b want=011", pif.vga_plot, pif.in_ready, idle);
    end
    total++;
    if (plot_count !== 16'd0 || clip_count !== 16'd0) begin
      bad++; $display("FAIL midreset_cnt got=%0d/%0d want=0/0", plot_count, clip_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (pif.vga_plot !== 1'b0) begin
      bad++; $display("FAIL stale_head got=%b want=0", pif.vga_plot);
    end
  endtask

  task automatic test_clip();
    int start;
    start = n_pop;
    pif.vga_ready = 1'b1;
    push_px(159, 119, 3'd1);
    push_px(160, 0, 3'd2);
    push_px(-1, 10, 3'd3);
    push_px(0, 120, 3'd4);
    push_px(0, 0, 3'd5);
    drain();
    tick();
    total++;
    if (plot_count !== 16'd2 || clip_count !== 16'd3) begin
      bad++; $display("FAIL clip_counts got=%0d/%0d want=2/3", plot_count, clip_count);
    end
    total++;
    if (n_pop - start != 2) begin
      bad++; $display("FAIL clip_pops got=%0d want=2", n_pop - start);
    end
  endtask

  task automatic test_backpressure();
    int start;
    start = n_pop;
    pif.vga_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_px(i * 9, i * 7, 3'(i));
    total++;
    if (pif.in_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready got=%b want=0", pif.in_ready);
    end
    pif.in_x = 9'd150; pif.in_y = 8'd110; pif.in_colour = 3'd6; pif.in_plot = 1'b1;
    tick(); tick(); tick();
    total++;
    if (pif.in_ready !== 1'b0 || pif.vga_x !== 8'd0 || pif.vga_y !== 7'd0) begin
      bad++; $display("FAIL stall_hold got=%b (%0d,%0d) want=0 (0,0)", pif.in_ready, pif.vga_x, pif.vga_y);
    end
    pif.vga_ready = 1'b1;
    push_px(150, 110, 3'd6);
    drain();
    total++;
    if (n_pop - start != 17) begin
      bad++; $display("FAIL bp_pops got=%0d want=17", n_pop - start);
    end
  endtask

  task automatic test_concurrent();
    pif.vga_ready = 1'b0;
    push_px(1, 1, 3'd1);
    push_px(2, 2, 3'd2);
    push_px(3, 3, 3'd3);
    pif.in_x = 9'd4; pif.in_y = 8'd4; pif.in_colour = 3'd4; pif.in_plot = 1'b1;
    pif.vga_ready = 1'b1;
    tick();
    pif.in_plot = 1'b0;
    pif.vga_ready = 1'b0;
    tick();
    total++;
    if ({pif.vga_x, pif.vga_y, pif.vga_colour} !== {8'd2, 7'd2, 3'd2} || q.size() != 3) begin
      bad++; $display("FAIL concur_head got=%h/%0d want=%h/3", {pif.vga_x, pif.vga_y, pif.vga_colour}, q.size(), {8'd2, 7'd2, 3'd2});
    end
    for (int i = 0; i < 13; i++) push_px(20 + i, 30 + i, 3'd7);
    pif.in_x = 9'd99; pif.in_y = 8'd99; pif.in_colour = 3'd5; pif.in_plot = 1'b1;
    pif.vga_ready = 1'b1;
    total++;
    if (pif.in_ready !== 1'b0) begin
      bad++; $display("FAIL full_noaccept got=%b want=0", pif.in_ready);
    end
    tick();
    pif.in_plot = 1'b0;
    pif.vga_ready = 1'b0;
    total++;
    if (pif.in_ready !== 1'b1 || q.size() != 15) begin
      bad++; $display("FAIL ready_after_pop got=%b/%0d want=1/15", pif.in_ready, q.size());
    end
    pif.vga_ready = 1'b1;
    drain();
  endtask

  task automatic test_clr();
    pif.vga_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_px(40 + i, 50 + i, 3'(i));
    pif.in_x = 9'd70; pif.in_y = 8'd70; pif.in_colour = 3'd2; pif.in_plot = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pif.in_plot = 1'b0;
    total++;
    if (pif.vga_plot !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL clr_empty got=%b%b want=01", pif.vga_plot, idle);
    end
    total++;
    if (plot_count !== 16'd0 || clip_count !== 16'd0) begin
      bad++; $display("FAIL clr_cnt got=%0d/%0d want=0/0", plot_count, clip_count);
    end
    pif.vga_ready = 1'b1;
    tick(); tick();
    total++;
    if (pif.vga_plot !== 1'b0) begin
      bad++; $display("FAIL clr_lost got=%b want=0", pif.vga_plot);
    end
  endtask

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic test_end_to_end();
    int vx[3];
    int vy[3];
    int dy;
    vx[0] = 80;  vy[0] = 14;
    vx[1] = 40;  vy[1] = 83;
    vx[2] = 120; vy[2] = 83;
    rand_ready = 1;
    for (int v = 0; v < 3; v++) begin
      for (int dx = -80; dx <= 80; dx += 4) begin
        dy = isqrt(6400 - dx * dx);
        push_px(vx[v] + dx, vy[v] + dy, 3'b101);
        push_px(vx[v] + dx, vy[v] - dy, 3'b101);
      end
    end
    drain();
    rand_ready = 0;
    pif.vga_ready = 1'b0;
    tick();
    total++;
    if (idle !== 1'b1) begin
      bad++; $display("FAIL e2e_idle got=%b want=1", idle);
    end
    total++;
    if (plot_count !== 16'(exp_plot) || clip_count !== 16'(exp_clip) || plot_count + clip_count !== 16'd246) begin
      bad++; $display("FAIL e2e_counts got=%0d/%0d want=%0d/%0d sum 246", plot_count, clip_count, exp_plot, exp_clip);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    pif.in_x = '0;
    pif.in_y = '0;
    pif.in_colour = '0;
    pif.in_plot = 1'b0;
    pif.vga_ready = 1'b0;
    test_reset();
    test_clip();
    test_backpressure();
    test_concurrent();
    test_clr();
    test_end_to_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
